// File: rtl/writeback_unit_if.sv
// Execute-side, data-memory and register-file signals of the write-back stage.
// slave is the write-back unit's view; master is the surrounding pipeline/memory.
interface writeback_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              ex_valid;
  logic              ex_ready;
  logic              ex_reg_write;
  logic              ex_is_load;
  logic [REG_AW-1:0] ex_dest;
  logic [DATA_W-1:0] ex_alu_result;

  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              load_err;

  modport slave (
    input  ex_valid, ex_reg_write, ex_is_load, ex_dest, ex_alu_result,
    output ex_ready,
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output wb_we, wb_addr, wb_data, load_err
  );

  modport master (
    output ex_valid, ex_reg_write, ex_is_load, ex_dest, ex_alu_result,
    input  ex_ready,
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  wb_we, wb_addr, wb_data, load_err
  );
endinterface

// File: rtl/writeback_unit.sv
// Final pipeline stage: writes ALU results directly, runs the data-memory load
// handshake (req/gnt then rvalid with timeout), and counts retired writes.
module writeback_unit #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  writeback_unit_if.slave  bus,
  output logic [CNT_W-1:0] retired_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state_reg, state_next;
  logic              wb_we_reg, wb_we_next;
  logic [REG_AW-1:0] wb_addr_reg, wb_addr_next;
  logic [DATA_W-1:0] wb_data_reg, wb_data_next;
  logic              mem_req_reg, mem_req_next;
  logic [DATA_W-1:0] mem_addr_reg, mem_addr_next;
  logic              load_err_reg, load_err_next;
  logic [CNT_W-1:0]  retired_reg, retired_next;
  logic [TW-1:0]     tmo_reg, tmo_next;
  logic [REG_AW-1:0] dest_reg, dest_next;
  logic              wflag_reg, wflag_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wb_we_reg    <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= '0;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
      load_err_reg <= 1'b0;
      retired_reg  <= '0;
      tmo_reg      <= '0;
      dest_reg     <= '0;
      wflag_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wb_we_reg    <= wb_we_next;
      wb_addr_reg  <= wb_addr_next;
      wb_data_reg  <= wb_data_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
      load_err_reg <= load_err_next;
      retired_reg  <= retired_next;
      tmo_reg      <= tmo_next;
      dest_reg     <= dest_next;
      wflag_reg    <= wflag_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wb_we_next    = 1'b0;
    wb_addr_next  = wb_addr_reg;
    wb_data_next  = wb_data_reg;
    mem_req_next  = mem_req_reg;
    mem_addr_next = mem_addr_reg;
    load_err_next = 1'b0;
    retired_next  = retired_reg + CNT_W'(wb_we_reg);
    tmo_next      = tmo_reg;
    dest_next     = dest_reg;
    wflag_next    = wflag_reg;

    case (state_reg)
      IDLE: begin
        if (bus.ex_valid) begin
          if (!bus.ex_is_load) begin
            // Register 0 is hard-wired; addr/data only move on a real write.
            if (bus.ex_reg_write && (bus.ex_dest != '0)) begin
              wb_we_next   = 1'b1;
              wb_addr_next = bus.ex_dest;
              wb_data_next = bus.ex_alu_result;
            end
          end else begin
            dest_next     = bus.ex_dest;
            wflag_next    = bus.ex_reg_write && (bus.ex_dest != '0);
            mem_addr_next = bus.ex_alu_result;
            mem_req_next  = 1'b1;
            state_next    = REQ;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          mem_req_next = 1'b0;
          tmo_next     = '0;
          state_next   = WAIT;
        end
      end
      WAIT: begin
        // Returned data takes priority over a timeout in the same cycle.
        if (bus.mem_rvalid) begin
          wb_we_next = wflag_reg;
          if (wflag_reg) begin
            wb_addr_next = dest_reg;
            wb_data_next = bus.mem_rdata;
          end
          state_next = IDLE;
        end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
          load_err_next = 1'b1;
          tmo_next      = '0;
          state_next    = IDLE;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.ex_ready = (state_reg == IDLE);
  assign bus.mem_req  = mem_req_reg;
  assign bus.mem_addr = mem_addr_reg;
  assign bus.wb_we    = wb_we_reg;
  assign bus.wb_addr  = wb_addr_reg;
  assign bus.wb_data  = wb_data_reg;
  assign bus.load_err = load_err_reg;
  assign retired_cnt  = retired_reg;
endmodule
